pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage pipeline. It sequences the IF/ID and ID/EX pipeline registers by driving their load-enable and flush inputs. It also selects EX operand forwarding sources and holds the back end during multi-cycle memory waits. It sits beside the ID stage and observes the destination and control fields carried through ID/EX, EX/MEM and MEM/WB.

Parameters:
LOAD_LAT, 1, stall cycles inserted per load-use hazard (1..15)
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset (0 = reset)
RS1_ID  in  5  source register 1 of the instruction in ID
RS2_ID  in  5  source register 2 of the instruction in ID
USE1_ID  in  1  ID instruction reads RS1
USE2_ID  in  1  ID instruction reads RS2
RD_EX  in  5  destination in EX (ID/EX RD_out)
RF_LE_EX  in  1  EX instruction writes the register file
L_EX  in  1  EX instruction is a load
RD_MEM  in  5  destination in MEM
RF_LE_MEM  in  1  MEM instruction writes the register file
RD_WB  in  5  destination in WB
RF_LE_WB  in  1  WB instruction writes the register file
BR_TAKEN_EX  in  1  branch, jump or call resolved taken in EX
MEM_BUSY  in  1  data memory is not ready
PC_LE  out  1  PC load enable
IFID_LE  out  1  IF/ID load enable
IFID_FLUSH  out  1  IF/ID flush
IDEX_FLUSH  out  1  ID/EX flush (bubble insert)
PIPE_HOLD  out  1  freeze EX/MEM and MEM/WB
FWD_A  out  2  operand A source: 0=RF, 1=EX, 2=MEM, 3=WB
FWD_B  out  2  operand B source, same encoding
STATE  out  2  0=RUN, 1=LOAD_STALL, 2=MEM_WAIT
STALL_CNT  out  CNT_W  stall cycles, saturating
FLUSH_CNT  out  CNT_W  branch flush events, saturating

Behaviour:
- Control outputs (PC_LE, IFID_LE, IFID_FLUSH, IDEX_FLUSH, PIPE_HOLD, FWD_*) are combinational from the current state and inputs. STATE, the stall down-counter, the saved state and both counters are registered on posedge clk.
- Reset asserted (reset=0), effective immediately and asynchronously:
  - STATE=RUN, internal counter=0, STALL_CNT=0, FLUSH_CNT=0.
  - PC_LE=0, IFID_LE=0, IFID_FLUSH=1, IDEX_FLUSH=1, PIPE_HOLD=0, FWD_A=FWD_B=0.
  - Reset asserted mid-stall or mid-wait abandons it; the controller restarts in RUN.
- Hazard definitions:
  - Register 0 never creates a hazard or a forward.
  - hitX(rs,use) = use && RF_LE_X && RD_X==rs && rs!=0.
  - load_use = L_EX && (hitEX(RS1_ID,USE1_ID) || hitEX(RS2_ID,USE2_ID)).
- Forwarding, per operand:
  - Priority: EX, then MEM, then WB, else RF.
  - EX is never selected when L_EX=1; that case is covered by the stall.
  - Forward values are valid in every state.
- Priority in RUN, highest first:
  1. MEM_BUSY=1: MEM_WAIT actions.
  2. BR_TAKEN_EX=1: PC_LE=1, IFID_LE=1, IFID_FLUSH=1, IDEX_FLUSH=1; FLUSH_CNT+1; stay in RUN. A branch overrides a simultaneous load_use, because the dependent instruction is flushed.
  3. load_use=1: PC_LE=0, IFID_LE=0, IDEX_FLUSH=1; STALL_CNT+1. If LOAD_LAT>1, load counter=LOAD_LAT-1 and go to LOAD_STALL.
  4. Otherwise: PC_LE=1, IFID_LE=1, IFID_FLUSH=0, IDEX_FLUSH=0.
- LOAD_STALL:
  - Each cycle: PC_LE=0, IFID_LE=0, IDEX_FLUSH=1; STALL_CNT+1; counter-1.
  - Go to RUN on the cycle the counter reaches 0 (counter==1 decrements to 0).
  - BR_TAKEN_EX is ignored here, since EX holds a bubble.
- MEM_WAIT, entered from RUN or LOAD_STALL when MEM_BUSY=1:
  - Save the current state; the counter is preserved.
  - Each cycle: PC_LE=0, IFID_LE=0, IFID_FLUSH=0, IDEX_FLUSH=0, PIPE_HOLD=1; STALL_CNT+1.
  - When MEM_BUSY drops, return to the saved state on the next edge, with counter intact.
  - A branch or load_use present during the wait is acted on after return. The wait does not consume or alter it.
- Counters saturate at 2^CNT_W-1 and never wrap.

Test Plan:
- Reset pulse mid-LOAD_STALL (LOAD_LAT=3) -> STATE=0 and counters 0 immediately; IDEX_FLUSH=1 while reset=0; after release, PC_LE=1 and no residual stall.
- Load-use: L_EX=1, RF_LE_EX=1, RD_EX=5, RS1_ID=5, USE1_ID=1, LOAD_LAT=1 -> exactly 1 cycle of PC_LE=0 and IDEX_FLUSH=1, STALL_CNT=1; with LOAD_LAT=3 -> 3 stall cycles, STALL_CNT=3.
- Register-0 and forwarding: RD_EX=0 load with RS1_ID=0 -> no stall, FWD_A=0. RD_EX=RD_MEM=7 (non-load), RS2_ID=7 -> FWD_B=1. Then clear RF_LE_EX -> FWD_B=2.
- Branch with simultaneous load_use -> single cycle IFID_FLUSH=IDEX_FLUSH=1, PC_LE=1, FLUSH_CNT=1, STALL_CNT unchanged.
- MEM_BUSY high 4 cycles during LOAD_STALL (counter=2) -> PIPE_HOLD=1 for 4 cycles, then 2 remaining stall cycles, STALL_CNT increases by 6.
- CNT_W=4, 20 consecutive stall cycles -> STALL_CNT holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline hazard, stall, flush and forwarding controller
module pipeline_hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             USE1_ID,
  input  logic             USE2_ID,
  input  logic [4:0]       RD_EX,
  input  logic             RF_LE_EX,
  input  logic             L_EX,
  input  logic [4:0]       RD_MEM,
  input  logic             RF_LE_MEM,
  input  logic [4:0]       RD_WB,
  input  logic             RF_LE_WB,
  input  logic             BR_TAKEN_EX,
  input  logic             MEM_BUSY,
  output logic             PC_LE,
  output logic             IFID_LE,
  output logic             IFID_FLUSH,
  output logic             IDEX_FLUSH,
  output logic             PIPE_HOLD,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

  state_e           state_q, state_d;
  state_e           saved_q, saved_d;
  state_e           eff_state;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic stall_inc, flush_inc;
  logic pc_le, ifid_le, ifid_flush, idex_flush, pipe_hold;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic hit(input logic [4:0] rs, input logic en,
                               input logic le, input logic [4:0] rd);
    return en && le && (rd == rs) && (rs != 5'd0);
  endfunction

  // A load in EX is never a forward source; the load-use stall covers it.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic en);
    if (hit(rs, en, RF_LE_EX, RD_EX) && !L_EX) return 2'd1;
    else if (hit(rs, en, RF_LE_MEM, RD_MEM))   return 2'd2;
    else if (hit(rs, en, RF_LE_WB, RD_WB))     return 2'd3;
    else                                       return 2'd0;
  endfunction

  assign load_use = L_EX && (hit(RS1_ID, USE1_ID, RF_LE_EX, RD_EX) ||
                             hit(RS2_ID, USE2_ID, RF_LE_EX, RD_EX));

  assign fwd_a = fwd_sel(RS1_ID, USE1_ID);
  assign fwd_b = fwd_sel(RS2_ID, USE2_ID);

  // Once memory is ready again the wait cycle already behaves as the saved state.
  assign eff_state = (state_q == ST_MEM_WAIT && !MEM_BUSY) ? saved_q : state_q;

  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    cnt_d      = cnt_q;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    pc_le      = 1'b0;
    ifid_le    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;

    if (MEM_BUSY) begin
      pipe_hold = 1'b1;
      stall_inc = 1'b1;
      state_d   = ST_MEM_WAIT;
      if (state_q != ST_MEM_WAIT) saved_d = state_q;
    end else begin
      case (eff_state)
        ST_LOAD_STALL: begin
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
          cnt_d      = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
          state_d    = (cnt_q <= 4'd1) ? ST_RUN : ST_LOAD_STALL;
        end
        default: begin
          state_d = ST_RUN;
          if (BR_TAKEN_EX) begin
            pc_le      = 1'b1;
            ifid_le    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
          end else if (load_use) begin
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
            if (LOAD_LAT > 1) begin
              cnt_d   = LAT_M1;
              state_d = ST_LOAD_STALL;
            end
          end else begin
            pc_le   = 1'b1;
            ifid_le = 1'b1;
          end
        end
      endcase
    end

    stall_cnt_d = (stall_inc && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush_inc && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      saved_q     <= ST_RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // While reset is held the front end is flushed and frozen.
  assign PC_LE      = reset ? pc_le      : 1'b0;
  assign IFID_LE    = reset ? ifid_le    : 1'b0;
  assign IFID_FLUSH = reset ? ifid_flush : 1'b1;
  assign IDEX_FLUSH = reset ? idex_flush : 1'b1;
  assign PIPE_HOLD  = reset ? pipe_hold  : 1'b0;
  assign FWD_A      = reset ? fwd_a      : 2'd0;
  assign FWD_B      = reset ? fwd_b      : 2'd0;
  assign STATE      = state_q;
  assign STALL_CNT  = stall_cnt_q;
  assign FLUSH_CNT  = flush_cnt_q;

endmodule
